fuzzy_pi_sampler: RTL
=====================

// Module: fuzzy_pi_sampler
// PURPOSE
//  Upstream front end of the fuzzy PI controller core. On each sample tick it latches setpoint and feedback,
//  forms error e and error increment de, scales each by a gain, saturates to Q1.(N-1), and presents them as x/y.
//  It then pulses start and waits for the core's rdy before accepting the next tick.
// PARAMETERS
//  N       16         data width of sp/fb/x/y and gains
//  bN      2          integer bits of gains ke/kde (unsigned Q bN.(N-bN))
//  PW      16         width of sample-period counter
//  TMO_CYC 4*N+16     rdy timeout in cycles (only with FPI_TIMEOUT_EN)
// PORTS
//  clk     in   1     clock
//  rst     in   1     synchronous reset, active-high
//  en      in   1     sampling enable
//  period  in   PW    sample period minus 1, in clk cycles
//  sp      in   N     setpoint, signed Q1.(N-1)
//  fb      in   N     feedback, signed Q1.(N-1)
//  ke      in   N     error gain, unsigned Q bN.(N-bN)
//  kde     in   N     error-increment gain, unsigned Q bN.(N-bN)
//  x       out  N     scaled error to core, signed Q1.(N-1)
//  y       out  N     scaled error increment to core, signed Q1.(N-1)
//  start   out  1     one-cycle start strobe to core
//  rdy     in   1     core result-ready strobe
//  busy    out  1     high in every state except IDLE
//  ovf     out  1     one-cycle pulse when x or y saturated on this sample
//  miss    out  1     one-cycle pulse when a tick arrives while busy
//  tmo     out  1     one-cycle pulse on rdy timeout (tied 0 without FPI_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: all outputs 0; e_prev=0; tick counter=0; FSM=IDLE.
//  Tick counter: counts 0..period while en=1, then wraps; tick asserted when cnt==period. period=0 -> tick every cycle.
//   en=0 holds cnt at 0; a sequence already in progress completes.
//  FSM: IDLE -tick&en-> LATCH -> MUL -> SAT -> STRT -> WAIT -rdy-> IDLE.
//   LATCH: register e=sp-fb (N+1 bit signed), de=e-e_prev (N+2 bit signed); e_prev<=e.
//   MUL:   register pe=e*ke, pde=de*kde (gains zero-extended, signed multiply).
//   SAT:   x<=sat_N(pe>>>(N-bN)), y<=sat_N(pde>>>(N-bN)); arithmetic shift (truncate toward -inf);
//          sat_N clamps to [-2^(N-1), 2^(N-1)-1]; ovf pulses if either clamped.
//   STRT:  start=1 for exactly one cycle. Latency tick -> start = 4 cycles.
//   WAIT:  leave on rdy=1. rdy in any other state is ignored, including the STRT cycle.
//  x/y change only in SAT and stay stable from SAT until the next SAT.
//  Tick in any non-IDLE state: miss=1 for that cycle, tick dropped; the counter keeps running.
//  Tick and rdy in the same cycle in WAIT: go to IDLE, tick counted as miss; sampling resumes on the next tick.
//  rst in any state: immediate return to reset values, including e_prev.
// CONFIGURATION
//  FPI_TIMEOUT_EN defined: WAIT counts cycles; on reaching TMO_CYC without rdy, tmo=1 for 1 cycle and FSM->IDLE;
//   x/y/e_prev keep their values.
//  FPI_TIMEOUT_EN undefined: WAIT waits indefinitely; tmo constant 0; no timeout counter synthesised.
// STRUCTURE
//  Shared include fuzzy_pi_defs.vh: FSM state encodings (IDLE..WAIT), Q-format constants (N, bN defaults), sat_N limits.
//  Sub-module fpi_sat_scale: registered product -> shift by N-bN -> saturate to N bits with clamp flag; instanced for x and y.
// TESTING (N=16, bN=2; gain 0x4000 = 1.0)
//  1 sp=0x2000, fb=0xE000, ke=kde=0x4000, e_prev=0 -> x=0x4000, y=0x4000, ovf=0, start 4 cycles after tick.
//  2 sp=0x7FFF, fb=0x8000, ke=0x4000 -> x=0x7FFF, ovf=1; then sp=0x8000, fb=0x7FFF -> x=0x8000, ovf=1.
//  3 period=9, rdy returned 3 cycles after start -> start exactly every 10 cycles, miss never asserts.
//  4 period=9, rdy returned 20 cycles after start -> miss pulses on ticks seen in WAIT; next start 4 cycles after first tick in IDLE.
//  5 FPI_TIMEOUT_EN, rdy never returned -> tmo pulse TMO_CYC cycles after entering WAIT, busy drops; without macro busy stays 1.
//  6 rst asserted for 1 cycle in WAIT -> next cycle all outputs 0, FSM IDLE; next sample y equals x (e_prev=0).

Source files
------------

// File: rtl/fuzzy_pi_sampler_pkg.sv
// Shared state encoding and Q-format defaults for the fuzzy PI sampler front end.
package fuzzy_pi_sampler_pkg;

  localparam int FPI_N  = 16;  // data width, signed Q1.(N-1)
  localparam int FPI_BN = 2;   // gain integer bits, unsigned Q bN.(N-bN)
  localparam int FPI_PW = 16;  // sample-period counter width

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_MUL   = 3'd2,
    S_SAT   = 3'd3,
    S_STRT  = 3'd4,
    S_WAIT  = 3'd5
  } fpi_state_t;

  function automatic int fpi_tmo_cyc(input int n);
    return 4 * n + 16;
  endfunction

endpackage

// File: rtl/fuzzy_pi_sampler_sat_scale.sv
// Product -> arithmetic shift right by SH -> clamp to signed N bits; combinational, no flow control.
// clamp flags that the shifted value did not fit and was forced to the nearest limit.
module fuzzy_pi_sampler_sat_scale #(
  parameter int IW = 34,
  parameter int N  = 16,
  parameter int SH = 14
) (
  input  logic signed [IW-1:0] prod,
  output logic        [N-1:0]  val,
  output logic                 clamp
);

  localparam int HW = IW - N + 1;

  logic signed [IW-1:0] shifted;
  logic        [HW-1:0] hi;

  always_comb begin
    shifted = prod >>> SH;
    // fits in N bits only when everything above the result's sign bit is a sign copy
    hi      = shifted[IW-1:N-1];
    clamp   = !((&hi) || !(|hi));
    if (!clamp)
      val = shifted[N-1:0];
    else if (shifted[IW-1])
      val = {1'b1, {(N-1){1'b0}}};
    else
      val = {1'b0, {(N-1){1'b1}}};
  end

endmodule

// File: rtl/fuzzy_pi_sampler.sv
// Fuzzy PI front end: per tick forms e/de, scales, saturates to x/y and strobes start; tick->start 4 cycles.
// Holds in WAIT until rdy; ticks while busy are dropped with miss. FPI_TIMEOUT_EN adds a rdy timeout (tmo).
module fuzzy_pi_sampler
  import fuzzy_pi_sampler_pkg::*;
#(
  parameter int N  = FPI_N,
  parameter int bN = FPI_BN,
  parameter int PW = FPI_PW
`ifdef FPI_TIMEOUT_EN
  , parameter int TMO_CYC = fpi_tmo_cyc(N)
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [PW-1:0] period,
  input  logic [N-1:0]  sp,
  input  logic [N-1:0]  fb,
  input  logic [N-1:0]  ke,
  input  logic [N-1:0]  kde,
  output logic [N-1:0]  x,
  output logic [N-1:0]  y,
  output logic          start,
  input  logic          rdy,
  output logic          busy,
  output logic          ovf,
  output logic          miss,
  output logic          tmo
);

  localparam int EW  = N + 1;
  localparam int DW  = N + 2;
  localparam int PEW = 2 * EW;
  localparam int PDW = 2 * DW;
  localparam int SH  = N - bN;

  fpi_state_t            state;
  logic [PW-1:0]         cnt;
  logic                  tick;
  logic signed [EW-1:0]  e_now;
  logic signed [EW-1:0]  e;
  logic signed [EW-1:0]  e_prev;
  logic signed [DW-1:0]  de;
  logic signed [PEW-1:0] pe;
  logic signed [PDW-1:0] pde;
  logic [N-1:0]          x_sat;
  logic [N-1:0]          y_sat;
  logic                  x_clamp;
  logic                  y_clamp;

`ifdef FPI_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] wcnt;
`else
  assign tmo = 1'b0;
`endif

  assign tick  = en && (cnt == period);
  assign miss  = tick && (state != S_IDLE);
  assign e_now = $signed({sp[N-1], sp}) - $signed({fb[N-1], fb});

  // Free-running sample timer; keeps counting through a busy sequence.
  always_ff @(posedge clk) begin
    if (rst || !en)
      cnt <= '0;
    else if (cnt >= period)
      cnt <= '0;
    else
      cnt <= cnt + PW'(1);
  end

  fuzzy_pi_sampler_sat_scale #(.IW(PEW), .N(N), .SH(SH)) u_sat_x (
    .prod  (pe),
    .val   (x_sat),
    .clamp (x_clamp)
  );

  fuzzy_pi_sampler_sat_scale #(.IW(PDW), .N(N), .SH(SH)) u_sat_y (
    .prod  (pde),
    .val   (y_sat),
    .clamp (y_clamp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      e      <= '0;
      e_prev <= '0;
      de     <= '0;
      pe     <= '0;
      pde    <= '0;
      x      <= '0;
      y      <= '0;
      start  <= 1'b0;
      busy   <= 1'b0;
      ovf    <= 1'b0;
`ifdef FPI_TIMEOUT_EN
      wcnt   <= '0;
      tmo    <= 1'b0;
`endif
    end else begin
      start <= 1'b0;
      ovf   <= 1'b0;
`ifdef FPI_TIMEOUT_EN
      tmo   <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (tick) begin
            state <= S_LATCH;
            busy  <= 1'b1;
          end
        end
        S_LATCH: begin
          e      <= e_now;
          de     <= $signed({e_now[EW-1], e_now}) - $signed({e_prev[EW-1], e_prev});
          e_prev <= e_now;
          state  <= S_MUL;
        end
        S_MUL: begin
          // operands widened to the product width so the signed multiply is exact
          pe    <= $signed({{EW{e[EW-1]}}, e}) * $signed({{(PEW-N){1'b0}}, ke});
          pde   <= $signed({{DW{de[DW-1]}}, de}) * $signed({{(PDW-N){1'b0}}, kde});
          state <= S_SAT;
        end
        S_SAT: begin
          x     <= x_sat;
          y     <= y_sat;
          ovf   <= x_clamp || y_clamp;
          start <= 1'b1;
          state <= S_STRT;
        end
        S_STRT: begin
          state <= S_WAIT;
`ifdef FPI_TIMEOUT_EN
          wcnt  <= '0;
`endif
        end
        S_WAIT: begin
          if (rdy) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
`ifdef FPI_TIMEOUT_EN
          else if (wcnt == TW'(TMO_CYC - 1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            tmo   <= 1'b1;
          end else begin
            wcnt <= wcnt + TW'(1);
          end
`endif
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
